// File: rtl/morty_ifid_queue.sv
// morty_ifid_queue: DEPTH-entry IF/ID FIFO (if_* push side with if_valid/if_ready, id_* pop side with id_valid/id_ready, id_flush, id_count, NOP bubble when empty; `define MORTY_IFID_PERF_EN adds stall_cycles/bubble_cycles)
module morty_ifid_queue #(
  parameter int XLEN = 32,
  parameter int EXC_W = 4,
  parameter int DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INST = 'h33
) (
  input  logic clk,
  input  logic rst,
  input  logic id_flush,
  input  logic if_valid,
  output logic if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_inst,
  input  logic [EXC_W-1:0] if_exception_i,
  input  logic if_trap_valid,
  input  logic [XLEN-1:0] if_exc_data,
  output logic id_valid,
  input  logic id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst,
  output logic [EXC_W-1:0] id_exception_o,
  output logic [XLEN-1:0] id_exc_data,
  output logic id_trap_valid,
`ifdef MORTY_IFID_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] bubble_cycles,
`endif
  output logic [$clog2(DEPTH):0] id_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [XLEN-1:0] pc_m [DEPTH];
  logic [XLEN-1:0] inst_m [DEPTH];
  logic [EXC_W-1:0] exc_m [DEPTH];
  logic [XLEN-1:0] data_m [DEPTH];
  logic trap_m [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic full, empty, push, pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push = if_valid && !full && !id_flush;
  assign pop = !empty && id_ready && !id_flush;
  always_ff @(posedge clk) begin
    if (rst || id_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_m[wr_ptr] <= if_pc;
      inst_m[wr_ptr] <= if_inst;
      exc_m[wr_ptr] <= if_exception_i;
      data_m[wr_ptr] <= if_exc_data;
      trap_m[wr_ptr] <= if_trap_valid;
    end
  end
  always_comb begin
    if_ready = !full;
    id_valid = !empty;
    id_count = count;
    id_pc = empty ? '0 : pc_m[rd_ptr];
    id_inst = empty ? NOP_INST : inst_m[rd_ptr];
    id_exception_o = empty ? '0 : exc_m[rd_ptr];
    id_exc_data = empty ? '0 : data_m[rd_ptr];
    id_trap_valid = !empty && trap_m[rd_ptr];
  end
`ifdef MORTY_IFID_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      bubble_cycles <= '0;
    end else begin
      stall_cycles <= stall_cycles + 32'(id_valid && !id_ready);
      bubble_cycles <= bubble_cycles + 32'(!id_valid && id_ready);
    end
  end
`endif
endmodule

// File: tb/tb_morty_ifid_queue.sv
// tb_morty_ifid_queue: scoreboard bench for morty_ifid_queue with a queue-based reference model and random traffic
module tb_morty_ifid_queue;
  localparam int DEPTH = 2;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [3:0] exc;
    logic trap;
    logic [31:0] data;
  } ent_t;
  logic clk = 0, rst = 1, id_flush = 0, if_valid = 0, id_ready = 0, if_trap_valid = 0;
  logic [31:0] if_pc = 0, if_inst = 0, if_exc_data = 0;
  logic [3:0] if_exception_i = 0;
  logic if_ready, id_valid, id_trap_valid;
  logic [31:0] id_pc, id_inst, id_exc_data;
  logic [3:0] id_exception_o;
  logic [$clog2(DEPTH):0] id_count;
`ifdef MORTY_IFID_PERF_EN
  logic [31:0] stall_cycles, bubble_cycles;
  logic [31:0] m_stall = 0, m_bubble = 0;
`endif
  int errs = 0, checks = 0, pre_cnt = 0;
  bit live = 0;
  ent_t sb[$];
  morty_ifid_queue #(.XLEN(32), .EXC_W(4), .DEPTH(DEPTH), .NOP_INST(32'h33)) dut (
    .clk(clk), .rst(rst), .id_flush(id_flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .if_exception_i(if_exception_i), .if_trap_valid(if_trap_valid), .if_exc_data(if_exc_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .id_exception_o(id_exception_o), .id_exc_data(id_exc_data), .id_trap_valid(id_trap_valid),
`ifdef MORTY_IFID_PERF_EN
    .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles),
`endif
    .id_count(id_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    if (live) begin
      chk("id_valid", 64'(id_valid), 64'(sb.size() > 0));
      chk("if_ready", 64'(if_ready), 64'(sb.size() < DEPTH));
      chk("id_count", 64'(id_count), 64'(sb.size()));
      if (sb.size() > 0) begin
        chk("id_pc", 64'(id_pc), 64'(sb[0].pc));
        chk("id_inst", 64'(id_inst), 64'(sb[0].inst));
        chk("id_exception_o", 64'(id_exception_o), 64'(sb[0].exc));
        chk("id_trap_valid", 64'(id_trap_valid), 64'(sb[0].trap));
        chk("id_exc_data", 64'(id_exc_data), 64'(sb[0].data));
      end else begin
        chk("bubble_pc", 64'(id_pc), 64'h0);
        chk("bubble_inst", 64'(id_inst), 64'h33);
        chk("bubble_exc", 64'(id_exception_o), 64'h0);
        chk("bubble_trap", 64'(id_trap_valid), 64'h0);
        chk("bubble_data", 64'(id_exc_data), 64'h0);
      end
`ifdef MORTY_IFID_PERF_EN
      chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
      chk("bubble_cycles", 64'(bubble_cycles), 64'(m_bubble));
`endif
    end
    pre_cnt = sb.size();
`ifdef MORTY_IFID_PERF_EN
    if (rst) begin
      m_stall = 0;
      m_bubble = 0;
    end else begin
      if (pre_cnt > 0 && !id_ready) m_stall = m_stall + 1;
      if (pre_cnt == 0 && id_ready) m_bubble = m_bubble + 1;
    end
`endif
    if (rst || id_flush) sb.delete();
    else if (sb.size() > 0 && id_ready) void'(sb.pop_front());
    if (rst) live = 1;
  end
  always @(posedge clk)
    if (!rst && !id_flush && if_valid && pre_cnt < DEPTH)
      sb.push_back('{if_pc, if_inst, if_exception_i, if_trap_valid, if_exc_data});
  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl, input logic r,
                       input logic [3:0] ex = 0, input logic tr = 0, input logic [31:0] d = 0);
    @(posedge clk);
    #1;
    if_valid = v;
    if_pc = pc;
    if_inst = {pc[23:0], 8'h13};
    if_exception_i = ex;
    if_trap_valid = tr;
    if_exc_data = d;
    id_ready = rdy;
    id_flush = fl;
    rst = r;
  endtask
  initial begin
    repeat (2) drive(0, 0, 0, 0, 1);
    repeat (2) drive(0, 0, 0, 0, 0);
    drive(1, 'h100, 0, 0, 0);
    drive(1, 'h104, 0, 0, 0);
    drive(1, 'h108, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, 32'(i * 4), 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(1, 'h200, 0, 0, 0);
    drive(1, 'h204, 0, 1, 0);
    repeat (2) drive(0, 0, 1, 0, 0);
    drive(1, 'h300, 0, 0, 0, 4'hC, 1, 32'hDEADBEEF);
    repeat (2) drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(1, 'h400, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 0);
    repeat (4) drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    repeat (3000)
      drive($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
            $urandom_range(0, 49) == 0, 4'($urandom), 1'($urandom), $urandom);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
